// File: rtl/regfile_dump_unit_if.sv
// Output word stream of regfile_dump_unit: one register word plus its index per
// valid/ready transfer.
interface regfile_dump_unit_if #(
   parameter int WIDTH = 32,
   parameter int IDXW  = 5
);
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [IDXW-1:0]  out_index;

   modport master (output out_valid, output out_data, output out_index, input out_ready);
   modport slave  (input out_valid, input out_data, input out_index, output out_ready);
endinterface

// File: rtl/regfile_dump_unit.sv
// Snapshots a flattened register file on start, then streams it out one word per
// handshake with its index while accumulating a running checksum.
module regfile_dump_unit #(
   parameter int NUM_REGS  = 32,
   parameter int WIDTH     = 32,
   parameter bit SKIP_ZERO = 1'b0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [NUM_REGS*WIDTH-1:0] registers,
   regfile_dump_unit_if.master       out_if,
   output logic                      busy,
   output logic                      done,
   output logic [WIDTH-1:0]          checksum
);
   localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_REGS - 1);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t           state_q, state_d;
   logic [IDXW-1:0]  index_q, index_d;
   logic [WIDTH-1:0] checksum_q, checksum_d;
   logic [WIDTH-1:0] snapshot_q [NUM_REGS];

   logic [WIDTH-1:0] curWord;
   logic             presentWord;
   logic             transfer;
   logic             capture;

   // Valid depends only on registered state, so out_ready never reaches out_valid.
   always_comb begin
      curWord     = snapshot_q[index_q];
      presentWord = (state_q == SEND) && (!SKIP_ZERO || (curWord != '0));
      transfer    = presentWord && out_if.out_ready;
      capture     = (state_q == IDLE) && start;
      state_d     = state_q;
      index_d     = index_q;
      checksum_d  = checksum_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = SEND;
               index_d    = '0;
               checksum_d = '0;
            end
         end
         SEND: begin
            // A suppressed zero word advances exactly like a completed transfer.
            if (transfer || !presentWord) begin
               if (transfer) begin
                  checksum_d = checksum_q + curWord;
               end
               if (index_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  index_d = index_q + IDXW'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         index_q    <= '0;
         checksum_q <= '0;
      end else begin
         state_q    <= state_d;
         index_q    <= index_d;
         checksum_q <= checksum_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            snapshot_q[i] <= '0;
         end
      end else if (capture) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            snapshot_q[i] <= registers[i*WIDTH +: WIDTH];
         end
      end
   end

   assign out_if.out_valid = presentWord;
   assign out_if.out_data  = (state_q == SEND) ? curWord : '0;
   assign out_if.out_index = (state_q == SEND) ? index_q : '0;
   assign busy             = (state_q != IDLE);
   assign done             = (state_q == DONE);
   assign checksum         = checksum_q;
endmodule

// File: tb/tb_regfile_dump_unit.sv
// Randomised scoreboard bench for regfile_dump_unit: one instance with zero words
// streamed, one with zero words suppressed.
module tb_regfile_dump_unit;
   localparam int N    = 32;
   localparam int W    = 32;
   localparam int MAXK = 400;

   typedef struct packed {
      logic [4:0]   idx;
      logic [W-1:0] data;
   } word_t;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           start = 1'b0;
   logic           sel = 1'b0;
   logic           readyDrv = 1'b0;
   logic [N*W-1:0] registers = '0;
   logic           start0, start1;
   logic           busy0, done0, busy1, done1;
   logic [W-1:0]   checksum0, checksum1;

   int             vecCount = 0;
   int             missCount = 0;
   logic [W-1:0]   regModel [N];
   bit             readyPat [MAXK+1];
   word_t          q0[$];
   word_t          q1[$];

   regfile_dump_unit_if #(.WIDTH(W), .IDXW(5)) if0 ();
   regfile_dump_unit_if #(.WIDTH(W), .IDXW(5)) if1 ();

   assign if0.out_ready = readyDrv;
   assign if1.out_ready = readyDrv;
   assign start0 = start & ~sel;
   assign start1 = start & sel;

   regfile_dump_unit #(.NUM_REGS(N), .WIDTH(W), .SKIP_ZERO(1'b0)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .registers(registers),
      .out_if(if0.master), .busy(busy0), .done(done0), .checksum(checksum0));

   regfile_dump_unit #(.NUM_REGS(N), .WIDTH(W), .SKIP_ZERO(1'b1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .registers(registers),
      .out_if(if1.master), .busy(busy1), .done(done1), .checksum(checksum1));

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      vecCount++;
      if (act !== req) begin
         missCount++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Each presented word must match the head of the expected stream, stalled or not.
   always @(negedge clk) begin
      if (if0.out_valid === 1'b1) begin
         if (q0.size() == 0) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL dut0 extra word: got idx %0d data %h, required none", if0.out_index, if0.out_data);
         end else begin
            checkOutput("dut0 index", 32'(if0.out_index), 32'(q0[0].idx));
            checkOutput("dut0 data", if0.out_data, q0[0].data);
            if (readyDrv) void'(q0.pop_front());
         end
      end
      if (if1.out_valid === 1'b1) begin
         if (q1.size() == 0) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL dut1 extra word: got idx %0d data %h, required none", if1.out_index, if1.out_data);
         end else begin
            checkOutput("dut1 index", 32'(if1.out_index), 32'(q1[0].idx));
            checkOutput("dut1 data", if1.out_data, q1[0].data);
            if (readyDrv) void'(q1.pop_front());
         end
      end
   end

   // Expected stream, checksum and done cycle (counted from the capture edge).
   task automatic modelDump(input bit skip, output int expK, output logic [W-1:0] expSum);
      word_t w;
      int    k;
      expSum = '0;
      k = 1;
      for (int i = 0; i < N; i++) begin
         regModel[i] = registers[i*W +: W];
         if (!skip || regModel[i] != 0) begin
            w.idx  = 5'(i);
            w.data = regModel[i];
            if (skip) q1.push_back(w); else q0.push_back(w);
            expSum = expSum + regModel[i];
            while (k < MAXK && !readyPat[k]) k++;
            k++;
         end else begin
            k++;
         end
      end
      expK = k;
   endtask

   task automatic setRamp();
      for (int i = 0; i < N; i++) registers[i*W +: W] = 32'h1000 + 32'(i);
   endtask

   task automatic applyStimulus(input bit which, input int readyMode, input bit poke);
      int           expK, k, doneCount, doneK, qleft;
      logic [W-1:0] expSum;
      logic         selBusy, selDone, selValid;
      logic [W-1:0] selSum;
      sel = which;
      for (int p = 0; p <= MAXK; p++) begin
         case (readyMode)
            0:       readyPat[p] = 1'b1;
            1:       readyPat[p] = ((p - 1) % 3) == 0;
            default: readyPat[p] = (p >= 300) ? 1'b1 : 1'($urandom_range(0, 1));
         endcase
      end
      modelDump(which, expK, expSum);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      k = 1;
      doneCount = 0;
      doneK = 0;
      while (k < MAXK && !(doneCount > 0 && k > doneK + 2)) begin
         #1;
         start = 1'b0;
         readyDrv = readyPat[k];
         if (poke && k == 2) registers = '1;
         if (poke && k == 6) start = 1'b1;
         @(negedge clk);
         selBusy  = which ? busy1 : busy0;
         selDone  = which ? done1 : done0;
         selValid = which ? if1.out_valid : if0.out_valid;
         if (k == 1) checkOutput("busy after capture", 32'(selBusy), 32'd1);
         if (doneCount > 0 && k == doneK + 1) begin
            checkOutput("busy after done", 32'(selBusy), 32'd0);
            checkOutput("valid after done", 32'(selValid), 32'd0);
         end
         if (selDone === 1'b1) begin
            doneCount++;
            doneK = k;
            if (poke) start = 1'b1;
         end
         @(posedge clk);
         k++;
      end
      start = 1'b0;
      selSum = which ? checksum1 : checksum0;
      qleft = which ? q1.size() : q0.size();
      checkOutput("done pulse count", 32'(doneCount), 32'd1);
      checkOutput("done cycle", 32'(doneK), 32'(expK));
      checkOutput("checksum", selSum, expSum);
      checkOutput("words outstanding", 32'(qleft), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int k;
      // Asynchronous reset asserted mid-cycle must clear outputs without an edge.
      #13 reset = 1'b1;
      #1;
      checkOutput("reset valid0", 32'(if0.out_valid), 32'd0);
      checkOutput("reset data0", if0.out_data, 32'd0);
      checkOutput("reset index0", 32'(if0.out_index), 32'd0);
      checkOutput("reset busy0", 32'(busy0), 32'd0);
      checkOutput("reset done0", 32'(done0), 32'd0);
      checkOutput("reset checksum0", checksum0, 32'd0);
      checkOutput("reset valid1", 32'(if1.out_valid), 32'd0);
      checkOutput("reset busy1", 32'(busy1), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      readyDrv = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checkOutput("idle valid0", 32'(if0.out_valid), 32'd0);
         checkOutput("idle valid1", 32'(if1.out_valid), 32'd0);
      end

      setRamp();
      applyStimulus(1'b0, 0, 1'b0);
      checkOutput("ramp checksum const", checksum0, 32'h0002_01F0);
      setRamp();
      applyStimulus(1'b0, 1, 1'b0);
      checkOutput("stall checksum const", checksum0, 32'h0002_01F0);
      setRamp();
      applyStimulus(1'b0, 0, 1'b1);

      registers = '0;
      registers[3*W +: W]  = 32'hA;
      registers[31*W +: W] = 32'hB;
      applyStimulus(1'b1, 0, 1'b0);
      checkOutput("skip checksum const", checksum1, 32'h15);

      // Reset while word 10 is being presented.
      sel = 1'b0;
      setRamp();
      for (int p = 0; p <= MAXK; p++) readyPat[p] = 1'b1;
      begin
         int           dk;
         logic [W-1:0] ds;
         modelDump(1'b0, dk, ds);
      end
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      k = 1;
      while (k < 11) begin
         #1;
         start = 1'b0;
         readyDrv = 1'b1;
         @(posedge clk);
         k++;
      end
      #3 reset = 1'b1;
      #1;
      q0.delete();
      checkOutput("midreset valid", 32'(if0.out_valid), 32'd0);
      checkOutput("midreset busy", 32'(busy0), 32'd0);
      checkOutput("midreset checksum", checksum0, 32'd0);
      checkOutput("midreset done", 32'(done0), 32'd0);
      #2 reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput("no done after reset", 32'(done0), 32'd0);
      end
      applyStimulus(1'b0, 0, 1'b0);

      // Random register contents (about a quarter zero) under random backpressure.
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < N; i++) begin
            registers[i*W +: W] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         end
         applyStimulus(1'(r % 2), 2, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end
endmodule

// File: doc/regfile_dump_unit.md
# regfile_dump_unit

Sequential unloader that sits directly downstream of the CPU's flattened register-file export bus, `registers[1023:0]`. On a `start` pulse it snapshots all 32 architectural registers. It then streams them out one 32-bit word per transfer over a valid/ready handshake, tagging each word with its register index. It also accumulates a running checksum, so benches and debug logic can read machine state without a 1024-bit combinational fan-out.

## Interface
Parameters:
- NUM_REGS, 32, number of registers in the exported bus.
- WIDTH, 32, bits per register.
- SKIP_ZERO, 0, when 1 registers holding zero are not presented on the output.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  request a dump; sampled on rising edge.
- registers  input  NUM_REGS*WIDTH  flattened register file; register i occupies bits [WIDTH*i+WIDTH-1 : WIDTH*i].
- out_valid  output  1  out_data/out_index hold a word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_data  output  WIDTH  register contents from the snapshot.
- out_index  output  $clog2(NUM_REGS)  register number of out_data.
- busy  output  1  dump in progress, including the DONE cycle.
- done  output  1  one-cycle pulse after the last word.
- checksum  output  WIDTH  sum mod 2^WIDTH of all words transferred in the current or last dump.

## Operation
- States: IDLE, SEND, DONE. Reset enters IDLE.
- Reset values: out_valid=0, out_data=0, out_index=0, busy=0, done=0, checksum=0, snapshot=0.
- IDLE:
  - start=1 at an edge copies all of `registers` into the snapshot buffer, clears checksum, sets index=0 and goes to SEND.
  - start=0 stays in IDLE.
- SEND:
  - out_data=snapshot[index] and out_index=index.
  - Transfer occurs on an edge where out_valid&&out_ready. Checksum += out_data, truncated to WIDTH.
  - On transfer with index==NUM_REGS-1, go to DONE; otherwise index+1.
- SKIP_ZERO=1:
  - A zero word is never presented. In SEND, out_valid=0 for that word's cycle and index advances without a transfer.
  - A zero word at the last index still goes to DONE.
  - Each skipped word costs one cycle.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Snapshot isolation: changes on `registers` after the capture edge never affect the words output.
- start while busy (SEND or DONE) is ignored. A start on the edge leaving DONE is also ignored; the next start is accepted in IDLE.
- checksum holds its final value in IDLE until the next accepted start.
- Reset mid-dump, asynchronous: returns immediately to IDLE with all reset values. No done pulse.

## Timing
- Capture edge E0 samples start=1. From E0, state is SEND, busy=1 and out_valid=1 with word 0 (SKIP_ZERO=0).
- With out_ready held 1, transfers occur at edges E1..E32.
- done=1 in the cycle after E32; busy falls and state is IDLE after E33.
- Minimum start-to-done latency is 33 cycles. Each cycle of out_ready=0 during valid adds one cycle.
- out_data and out_index are stable while out_valid=1 and out_ready=0. out_valid never drops without a transfer.
- out_ready is ignored when out_valid=0. Combinational out_ready→out_valid paths are forbidden.

## Test plan
- Reset: assert reset mid-cycle asynchronously → all outputs 0 immediately; after release, out_valid stays 0 with start=0 for 10 cycles.
- Full dump with out_ready=1 and register i = 0x1000+i → 32 transfers, out_index 0..31 in order, out_data 0x1000..0x101F. done pulses once at cycle E0+33; checksum=0x000201F0.
- Backpressure: same data, out_ready toggling 1,0,0,1,... → words and indices unchanged while stalled; order preserved; checksum=0x000201F0; done delayed by the stall count.
- Isolation and ignored start: after capture, overwrite `registers` with 0xFFFFFFFF each and pulse start at word 5 → output is still 0x1000+i; exactly one done pulse.
- SKIP_ZERO=1 with only reg 3=0xA, reg 31=0xB nonzero → exactly two transfers (index 3, index 31); checksum=0x15; done after the reg-31 transfer.
- Reset mid-dump at word 10 → out_valid=0, busy=0, checksum=0 immediately; no done. A new start then dumps from index 0.
